hpdl_bus_monitor: RTL and testbench
===================================

Name: hpdl_bus_monitor

Overview:
Passive monitor on the HPDL-1414 display bus: samples the four WR strobes, the two address lines and the 7-bit data lines driven by the display driver. It rebuilds the 16-character shadow of what the four displays hold. On request it streams that shadow back out through the existing uart_transmitter, so the host can read back the displayed text. It sits beside the display driver in the top level and uses the same CLK domain. The bus inputs are treated as asynchronous.

Parameters:
ADDR_INVERT, 1, 1 = address pins carry inverted digit index (digit = ~{A1,A0}); 0 = straight.
APPEND_CRLF, 1, 1 = append 0x0D, 0x0A after the 16 characters of a dump.
SETTLE_CYCLES, 2, cycles after o_tx_start before i_tx_busy is trusted (range 1..7).
RESET_CHAR, 7'h20, value of every shadow/snapshot cell after reset.

Ports:
i_clk  in  1  system clock (12 MHz CLK).
i_reset  in  1  synchronous, active-high reset.
i_wr_n  in  4  HPDL_WR1..WR4, active-low, bit k = chip k (asynchronous).
i_addr  in  2  {HPDL_A1, HPDL_A0} (asynchronous).
i_data  in  7  HPDL_D6..D0 (asynchronous).
i_dump_req  in  1  one-cycle request to transmit the shadow.
i_tx_busy  in  1  TxD_busy from uart_transmitter.
o_tx_start  out  1  one-cycle TxD_start pulse.
o_tx_data  out  8  TxD_data byte, valid while o_tx_start is high.
o_dump_busy  out  1  high from dump acceptance until the last byte completes.
o_wr_strobe  out  1  one-cycle pulse per committed bus write.
o_wr_pos  out  4  position of the last committed write (chip*4 + digit).
o_write_count  out  16  committed writes since reset; wraps at 0xFFFF -> 0.

Behaviour:
- Reset values: all outputs 0; shadow and snapshot cells = RESET_CHAR; FSM = IDLE.
- Reset is honoured in any state. A dump in progress is aborted, and o_tx_start is low from the cycle after i_reset is sampled high.
- Input sync: two-flop synchronizer on each of the 13 bus bits. All decoding uses the second stage (s_*).
- Capture: every cycle in which any s_wr_n bit is 0, register {s_wr_n, s_addr, s_data} into a hold register.
- Commit: on the cycle when a chip's s_wr_n goes 0->1, write the held data into shadow[chip*4 + digit]. This uses the hold register (the last low-phase sample), not the current bus values, so address/data changing coincident with WR rising is tolerated.
- Digit = ADDR_INVERT ? ~held_addr : held_addr.
- Several chips rising in the same cycle: write every such chip at its own position.
  - o_wr_strobe pulses once.
  - o_write_count increments once per chip written.
  - o_wr_pos reports the lowest chip index.
- Commit latency: bus WR rising edge -> shadow updated and o_wr_strobe high 3 cycles later (2 sync + 1 edge detect).
- Dump FSM states: IDLE, SNAP, START, SETTLE, WAIT.
  - IDLE: if i_dump_req, go to SNAP; o_dump_busy is set the next cycle.
  - SNAP: copy the whole shadow into the snapshot in one cycle; byte index = 0.
  - START: when i_tx_busy == 0, assert o_tx_start for 1 cycle. o_tx_data = {1'b0, snapshot[idx]} for idx 0..15, then 0x0D, 0x0A if APPEND_CRLF. Go to SETTLE.
  - SETTLE: count SETTLE_CYCLES cycles, then go to WAIT.
  - WAIT: when i_tx_busy == 0, advance idx.
    - More bytes remain: go to START.
    - Last byte done: go to IDLE and clear o_dump_busy.
- Dump length is 16 bytes (APPEND_CRLF = 0) or 18 bytes (APPEND_CRLF = 1).
- i_dump_req while o_dump_busy is ignored, with no queuing.
- Bus writes during a dump update the shadow but not the snapshot; the dump is frame-coherent.
- Stored values are 7-bit raw; no filtering of codes outside 0x20..0x5F.
- o_tx_start is never asserted in a cycle where i_tx_busy is 1.

Test Plan:
- Reset then dump (APPEND_CRLF = 1): 18 start pulses; data 0x20 x16, then 0x0D, 0x0A; o_dump_busy falls after the 18th byte completes; o_write_count = 0.
- Single write, WR2 low 8 cycles, {A1,A0} = 2'b11, D = 0x41, ADDR_INVERT = 1: o_wr_strobe 3 cycles after WR2 rises; o_wr_pos = 4; dump byte 4 = 0x41, all others 0x20.
- Address/data change on the same edge WR1 rises (driver-style timing), A = 2'b10 -> 2'b01, D = 0x48 -> 0x49: position 1 holds 0x48.
- WR1 and WR4 low together, A = 2'b00, D = 0x5A: positions 3 and 15 = 0x5A; o_write_count += 2; o_wr_pos = 3; one strobe.
- Dump started, then write position 0 = 0x58 mid-dump: current dump sends 0x20 at byte 0; a second dump sends 0x58. i_dump_req during the dump produces no extra bytes.
- i_reset pulsed during byte 5 of a dump: o_tx_start stays 0, o_dump_busy = 0, shadow is back to 0x20. 65536 writes wrap o_write_count to 0.

Source files
------------

// File: rtl/hpdl_bus_monitor.sv
// Passive HPDL-1414 bus monitor: rebuilds the 16-character display shadow from
// the write strobes and streams a frozen copy of it to the UART on request.
module hpdl_bus_monitor #(
  parameter bit          ADDR_INVERT   = 1'b1,
  parameter bit          APPEND_CRLF   = 1'b1,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [6:0]  RESET_CHAR    = 7'h20
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [3:0]  i_wr_n,
  input  logic [1:0]  i_addr,
  input  logic [6:0]  i_data,
  input  logic        i_dump_req,
  input  logic        i_tx_busy,
  output logic        o_tx_start,
  output logic [7:0]  o_tx_data,
  output logic        o_dump_busy,
  output logic        o_wr_strobe,
  output logic [3:0]  o_wr_pos,
  output logic [15:0] o_write_count
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SNAP   = 3'd1,
    ST_START  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_WAIT   = 3'd4
  } dump_state_t;

  localparam logic [4:0] LAST_IDX    = APPEND_CRLF ? 5'd17 : 5'd15;
  localparam logic [2:0] SETTLE_LAST = 3'(SETTLE_CYCLES - 1);

  logic [3:0]  wr_n_meta_r, s_wr_n_r, prev_wr_n_r;
  logic [1:0]  addr_meta_r, s_addr_r, hold_addr_r;
  logic [6:0]  data_meta_r, s_data_r, hold_data_r;
  logic [6:0]  shadow_r   [16];
  logic [6:0]  snapshot_r [16];
  logic [3:0]  rise_s;
  logic [1:0]  digit_s;
  logic [1:0]  low_chip_s;
  logic [2:0]  rise_cnt_s;
  logic [7:0]  byte_s;
  dump_state_t state_r;
  logic [4:0]  idx_r;
  logic [2:0]  settle_cnt_r;
  logic        tx_start_r, dump_busy_r, wr_strobe_r;
  logic [7:0]  tx_data_r;
  logic [3:0]  wr_pos_r;
  logic [15:0] write_count_r;

  // Two-flop synchronizers; WR idles high so no phantom edge appears after reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_n_meta_r <= 4'hF;
      s_wr_n_r    <= 4'hF;
      prev_wr_n_r <= 4'hF;
      addr_meta_r <= 2'b00;
      s_addr_r    <= 2'b00;
      data_meta_r <= 7'h00;
      s_data_r    <= 7'h00;
    end else begin
      wr_n_meta_r <= i_wr_n;
      s_wr_n_r    <= wr_n_meta_r;
      prev_wr_n_r <= s_wr_n_r;
      addr_meta_r <= i_addr;
      s_addr_r    <= addr_meta_r;
      data_meta_r <= i_data;
      s_data_r    <= data_meta_r;
    end
  end

  // Hold the last low-phase sample so bus changes on the WR rising edge are harmless
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      hold_addr_r <= 2'b00;
      hold_data_r <= 7'h00;
    end else if (s_wr_n_r != 4'hF) begin
      hold_addr_r <= s_addr_r;
      hold_data_r <= s_data_r;
    end
  end

  // Rising-edge decode; scanning high to low leaves the lowest rising chip selected
  always_comb begin
    rise_s     = s_wr_n_r & ~prev_wr_n_r;
    digit_s    = ADDR_INVERT ? ~hold_addr_r : hold_addr_r;
    rise_cnt_s = 3'd0;
    low_chip_s = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      rise_cnt_s = rise_cnt_s + {2'b00, rise_s[k]};
      low_chip_s = rise_s[k] ? 2'(k) : low_chip_s;
    end
  end

  // Shadow update and write-event reporting
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < 16; i++) shadow_r[i] <= RESET_CHAR;
      wr_strobe_r   <= 1'b0;
      wr_pos_r      <= 4'd0;
      write_count_r <= 16'd0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (rise_s[k]) shadow_r[{2'(k), digit_s}] <= hold_data_r;
      end
      wr_strobe_r <= |rise_s;
      if (|rise_s) begin
        wr_pos_r      <= {low_chip_s, digit_s};
        write_count_r <= write_count_r + {13'd0, rise_cnt_s};
      end
    end
  end

  // Byte selected for the current dump index
  always_comb begin
    byte_s = 8'h0A;
    if (idx_r < 5'd16) begin
      byte_s = {1'b0, snapshot_r[idx_r[3:0]]};
    end else if (idx_r == 5'd16) begin
      byte_s = 8'h0D;
    end else begin
      byte_s = 8'h0A;
    end
  end

  // Dump sequencer: freeze the frame, then hand bytes to the UART one at a time
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < 16; i++) snapshot_r[i] <= RESET_CHAR;
      state_r      <= ST_IDLE;
      idx_r        <= 5'd0;
      settle_cnt_r <= 3'd0;
      tx_start_r   <= 1'b0;
      tx_data_r    <= 8'h00;
      dump_busy_r  <= 1'b0;
    end else begin
      tx_start_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (i_dump_req) begin
            state_r     <= ST_SNAP;
            dump_busy_r <= 1'b1;
          end
        end
        ST_SNAP: begin
          for (int i = 0; i < 16; i++) snapshot_r[i] <= shadow_r[i];
          idx_r   <= 5'd0;
          state_r <= ST_START;
        end
        ST_START: begin
          if (!i_tx_busy) begin
            tx_start_r   <= 1'b1;
            tx_data_r    <= byte_s;
            settle_cnt_r <= 3'd0;
            state_r      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt_r == SETTLE_LAST) state_r <= ST_WAIT;
          else settle_cnt_r <= settle_cnt_r + 3'd1;
        end
        ST_WAIT: begin
          if (!i_tx_busy) begin
            if (idx_r == LAST_IDX) begin
              state_r     <= ST_IDLE;
              dump_busy_r <= 1'b0;
            end else begin
              idx_r   <= idx_r + 5'd1;
              state_r <= ST_START;
            end
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          dump_busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign o_tx_start    = tx_start_r;
  assign o_tx_data     = tx_data_r;
  assign o_dump_busy   = dump_busy_r;
  assign o_wr_strobe   = wr_strobe_r;
  assign o_wr_pos      = wr_pos_r;
  assign o_write_count = write_count_r;

endmodule

// File: tb/tb_hpdl_bus_monitor.sv
// Self-checking bench for hpdl_bus_monitor: a reference shadow model feeds an
// expected-byte queue that is drained as the DUT emits UART start pulses.
module tb_hpdl_bus_monitor;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  wr_n;
  logic [1:0]  addr;
  logic [6:0]  data;
  logic        dump_req;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        dump_busy;
  logic        wr_strobe;
  logic [3:0]  wr_pos;
  logic [15:0] write_count;

  int          errors = 0;
  int          checks = 0;
  int          bytes_seen = 0;
  int          bcnt = 0;
  logic [7:0]  exp_q[$];
  logic [6:0]  model[16];
  logic [15:0] exp_count;

  always #5 clk = ~clk;

  hpdl_bus_monitor dut (
    .i_clk(clk), .i_reset(reset), .i_wr_n(wr_n), .i_addr(addr), .i_data(data),
    .i_dump_req(dump_req), .i_tx_busy(tx_busy), .o_tx_start(tx_start),
    .o_tx_data(tx_data), .o_dump_busy(dump_busy), .o_wr_strobe(wr_strobe),
    .o_wr_pos(wr_pos), .o_write_count(write_count)
  );

  // UART stand-in: busy for 10 cycles after each start pulse
  assign tx_busy = (bcnt != 0);
  always @(posedge clk) begin
    if (reset) bcnt <= 0;
    else if (tx_start) bcnt <= 10;
    else if (bcnt != 0) bcnt <= bcnt - 1;
  end

  // Scoreboard: every start pulse pops one expected byte
  always @(negedge clk) begin
    if (tx_start) begin
      bytes_seen++;
      checks++;
      if (tx_busy) begin
        errors++;
        $display("FAIL start_while_busy: tx_start=1 with tx_busy=%0b, required busy=0", tx_busy);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_byte: got 0x%02h, required no byte", tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (tx_data !== e) begin
          errors++;
          $display("FAIL dump_byte: got 0x%02h, required 0x%02h", tx_data, e);
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1; wr_n = 4'hF; addr = 2'b00; data = 7'h00; dump_req = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 16; i++) model[i] = 7'h20;
    exp_count = 16'd0;
  endtask

  task automatic start_dump(input bit expect_accept);
    @(negedge clk);
    dump_req = 1'b1;
    if (expect_accept) begin
      for (int i = 0; i < 16; i++) exp_q.push_back({1'b0, model[i]});
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
    @(negedge clk);
    dump_req = 1'b0;
    checks++;
    if (dump_busy !== 1'b1) begin
      errors++;
      $display("FAIL dump_busy_rise: got %0b, required 1", dump_busy);
    end
  endtask

  task automatic wait_dump_done(input int base_bytes);
    int n;
    n = 0;
    while (dump_busy === 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (dump_busy !== 1'b0) begin
      errors++;
      $display("FAIL dump_timeout: dump_busy=%0b after %0d cycles, required 0", dump_busy, n);
    end
    checks++;
    if (bytes_seen - base_bytes != 18 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL dump_length: got %0d bytes (%0d pending), required 18 (0 pending)",
               bytes_seen - base_bytes, exp_q.size());
    end
    checks++;
    if (tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL dump_busy_early: tx_busy=%0b when dump_busy fell, required 0", tx_busy);
    end
  endtask

  task automatic full_dump();
    int base;
    base = bytes_seen;
    start_dump(1'b1);
    wait_dump_done(base);
  endtask

  task automatic bus_write(input logic [3:0] mask, input logic [1:0] a, input logic [6:0] d,
                           input int low_cycles, input logic [1:0] a_rise, input logic [6:0] d_rise);
    logic [1:0] dg;
    logic [3:0] lp;
    logic [2:0] seq;
    bit         found;
    dg = ~a;
    lp = 4'd0;
    found = 1'b0;
    @(negedge clk);
    addr = a; data = d; wr_n = ~mask;
    repeat (low_cycles) @(negedge clk);
    wr_n = 4'hF; addr = a_rise; data = d_rise;
    for (int k = 0; k < 4; k++) begin
      if (mask[k]) begin
        model[k*4 + int'(dg)] = d;
        exp_count = exp_count + 16'd1;
        if (!found) begin
          lp = {2'(k), dg};
          found = 1'b1;
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      seq[k] = wr_strobe;
    end
    checks++;
    if (seq !== 3'b100) begin
      errors++;
      $display("FAIL strobe_latency: strobe cycles 1..3 = %b (bit0 first), required 100", seq);
    end
    checks++;
    if (wr_pos !== lp) begin
      errors++;
      $display("FAIL wr_pos: got %0d, required %0d", wr_pos, lp);
    end
    checks++;
    if (write_count !== exp_count) begin
      errors++;
      $display("FAIL write_count: got %0d, required %0d", write_count, exp_count);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({tx_start, dump_busy, wr_strobe} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: start/busy/strobe=%b, required 000", {tx_start, dump_busy, wr_strobe});
    end
    checks++;
    if ({tx_data, wr_pos, write_count} !== 28'd0) begin
      errors++;
      $display("FAIL reset_values: data=%h pos=%h count=%h, required all 0", tx_data, wr_pos, write_count);
    end
  endtask

  task automatic test_dump_after_reset();
    full_dump();
    checks++;
    if (write_count !== 16'd0) begin
      errors++;
      $display("FAIL count_after_dump: got %0d, required 0", write_count);
    end
  endtask

  task automatic test_single_write();
    bus_write(4'b0010, 2'b11, 7'h41, 8, 2'b11, 7'h41);
    full_dump();
  endtask

  task automatic test_driver_timing();
    bus_write(4'b0001, 2'b10, 7'h48, 4, 2'b01, 7'h49);
    full_dump();
  endtask

  task automatic test_multi_chip();
    bus_write(4'b1001, 2'b00, 7'h5A, 3, 2'b00, 7'h5A);
    full_dump();
  endtask

  task automatic test_mid_dump_write();
    int base, n;
    base = bytes_seen;
    start_dump(1'b1);
    n = 0;
    while (bytes_seen == base && n < 200) begin
      @(negedge clk);
      n++;
    end
    bus_write(4'b0001, 2'b11, 7'h58, 5, 2'b11, 7'h58);
    start_dump(1'b0);
    wait_dump_done(base);
    full_dump();
  endtask

  task automatic test_reset_mid_dump();
    int base, n, starts;
    base = bytes_seen;
    start_dump(1'b1);
    n = 0;
    while (bytes_seen - base < 5 && n < 500) begin
      @(negedge clk);
      n++;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 16; i++) model[i] = 7'h20;
    exp_count = 16'd0;
    starts = 0;
    for (int k = 0; k < 40; k++) begin
      if (tx_start) starts++;
      @(negedge clk);
    end
    checks++;
    if (starts != 0 || dump_busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_dump: %0d starts, dump_busy=%0b after reset, required 0 and 0", starts, dump_busy);
    end
    checks++;
    if (write_count !== 16'd0) begin
      errors++;
      $display("FAIL abort_count: got %0d, required 0", write_count);
    end
    full_dump();
  endtask

  task automatic test_count_wrap();
    do_reset();
    @(negedge clk);
    addr = 2'b00; data = 7'h33;
    for (int i = 0; i < 16383; i++) begin
      wr_n = 4'h0;
      @(negedge clk);
      wr_n = 4'hF;
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (write_count !== 16'hFFFC) begin
      errors++;
      $display("FAIL count_near_wrap: got %h, required fffc", write_count);
    end
    wr_n = 4'h0;
    @(negedge clk);
    wr_n = 4'hF;
    repeat (5) @(negedge clk);
    checks++;
    if (write_count !== 16'h0000) begin
      errors++;
      $display("FAIL count_wrap: got %h, required 0000", write_count);
    end
    for (int k = 0; k < 4; k++) model[k*4 + 3] = 7'h33;
    full_dump();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_dump_after_reset();
    test_single_write();
    test_driver_timing();
    test_multi_chip();
    test_mid_dump_write();
    test_reset_mid_dump();
    test_count_wrap();
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
